lcd_fill_sequencer: RTL and testbench

- Bus-mapped sequencer that owns the byte stream into the LCD SPI byte engine.
- Arbitrates between CPU single-byte passthrough writes and a hardware rectangle-fill engine.
- The fill engine emits CASET/RASET/RAMWR followed by N RGB565 pixels, so the CPU no longer bit-bangs every pixel byte.
- Sits between the CPU memory bus and the SPI byte engine; the engine drives the SPI pins and lcd_dc.

---
 rtl/lcd_fill_sequencer_if.sv | 31 +++
 rtl/lcd_fill_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_lcd_fill_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_fill_sequencer_if.sv
// Bus and byte-stream bundle for the LCD fill sequencer.
// master = CPU/engine side, slave = sequencer.
interface lcd_fill_sequencer_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        byte_ready;

  modport master (
    output address_in, sel_in, read_in,
    output write_mask_in, write_value_in,
    output byte_ready,
    input  read_value_out, ready_out,
    input  byte_valid, byte_data, byte_dc
  );

  modport slave (
    input  address_in, sel_in, read_in,
    input  write_mask_in, write_value_in,
    input  byte_ready,
    output read_value_out, ready_out,
    output byte_valid, byte_data, byte_dc
  );
endinterface

// File: rtl/lcd_fill_sequencer.sv
// LCD byte-stream sequencer: CPU passthrough writes plus a
// hardware CASET/RASET/RAMWR rectangle fill engine.
module lcd_fill_sequencer #(
  parameter int COORD_W = 9,
  parameter int PIX_W   = 18
) (
  input logic clk,
  input logic reset_n,
  lcd_fill_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CASET_CMD,
    CASET_PAR,
    RASET_CMD,
    RASET_PAR,
    RAMWR_CMD,
    PIX_HI,
    PIX_LO
  } state_t;

  localparam int PW = 2 * COORD_W + 2;

  state_t state;
  state_t nxt;

  logic [COORD_W-1:0] wx0, wx1, wy0, wy1;
  logic [COORD_W-1:0] sx0, sx1, sy0, sy1;
  logic [15:0]        color;
  logic [15:0]        scolor;
  logic [PIX_W-1:0]   rem;
  logic [1:0]         idx;
  logic               gap;
  logic               pt_valid;
  logic               pt_dc;
  logic [7:0]         pt_data;
  logic               abort_q;
  logic               done;
  logic               err;

  logic [3:0]  off;
  logic [31:0] wv;
  logic        wr, rd;
  logic        wr_data, wr_winx, wr_winy, wr_ctrl;
  logic        rd_stat;
  logic        start_req, abort_req;
  logic        fsm_act, busy, win_ok;
  logic        start_ok, start_err, data_err;
  logic        accept, offered;
  logic        abort_now, leave, last_px;
  logic        par_st;

  logic [COORD_W:0] nx, ny;
  logic [PW-1:0]    npix;
  logic [15:0]      coord;

  assign off = bus.address_in[3:0];
  assign wv  = bus.write_value_in;
  assign wr  = bus.sel_in && (|bus.write_mask_in);
  assign rd  = bus.sel_in && bus.read_in;

  assign wr_data = wr && (off == 4'h0);
  assign wr_winx = wr && (off == 4'h4);
  assign wr_winy = wr && (off == 4'h8);
  assign wr_ctrl = wr && (off == 4'hC);
  assign rd_stat = rd && (off == 4'hC);

  assign start_req = wr_ctrl && wv[16] && !wv[17];
  assign abort_req = wr_ctrl && wv[17];

  assign fsm_act = (state != IDLE);
  assign busy    = fsm_act || pt_valid;
  assign win_ok  = (wx1 >= wx0) && (wy1 >= wy0);

  assign start_ok  = start_req && !busy && win_ok;
  assign start_err = start_req && !start_ok;
  assign data_err  = wr_data && busy;

  assign accept  = bus.byte_valid && bus.byte_ready;
  assign offered = fsm_act && !gap;

  // An abort lets an offered byte finish its handshake first.
  assign abort_now = fsm_act && (abort_req || abort_q);
  assign leave     = abort_now && (accept || !offered);
  assign last_px   = (state == PIX_LO) && accept
                   && (rem == '0);

  assign par_st = (state == CASET_PAR)
               || (state == RASET_PAR);

  // Stored as count-1 so a full 2^COORD_W square still fits.
  assign nx   = {1'b0, wx1} - {1'b0, wx0}
              + (COORD_W+1)'(1);
  assign ny   = {1'b0, wy1} - {1'b0, wy0}
              + (COORD_W+1)'(1);
  assign npix = PW'(nx) * PW'(ny) - PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!fsm_act) begin
      if (start_ok) nxt = CASET_CMD;
    end else if (leave) begin
      nxt = IDLE;
    end else if (accept) begin
      unique case (state)
        CASET_CMD: nxt = CASET_PAR;
        CASET_PAR: if (idx == 2'd3) nxt = RASET_CMD;
        RASET_CMD: nxt = RASET_PAR;
        RASET_PAR: if (idx == 2'd3) nxt = RAMWR_CMD;
        RAMWR_CMD: nxt = PIX_HI;
        PIX_HI:    nxt = PIX_LO;
        PIX_LO:    nxt = (rem == '0) ? IDLE : PIX_HI;
        default:   nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    coord = '0;
    if (state == RASET_PAR)
      coord = 16'(idx[1] ? sy1 : sy0);
    else
      coord = 16'(idx[1] ? sx1 : sx0);
  end

  always_comb begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_dc    = 1'b0;
    if (!gap) begin
      unique case (state)
        IDLE: begin
          if (pt_valid) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = pt_data;
            bus.byte_dc    = pt_dc;
          end
        end
        CASET_CMD: begin
          bus.byte_valid = 1'b1;
          bus.byte_data  = 8'h2A;
        end
        RASET_CMD: begin
          bus.byte_valid = 1'b1;
          bus.byte_data  = 8'h2B;
        end
        RAMWR_CMD: begin
          bus.byte_valid = 1'b1;
          bus.byte_data  = 8'h2C;
        end
        CASET_PAR, RASET_PAR: begin
          bus.byte_valid = 1'b1;
          bus.byte_dc    = 1'b1;
          bus.byte_data  = idx[0] ? coord[7:0]
                                  : coord[15:8];
        end
        PIX_HI: begin
          bus.byte_valid = 1'b1;
          bus.byte_dc    = 1'b1;
          bus.byte_data  = scolor[15:8];
        end
        PIX_LO: begin
          bus.byte_valid = 1'b1;
          bus.byte_dc    = 1'b1;
          bus.byte_data  = scolor[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wx0      <= '0;
      wx1      <= '0;
      wy0      <= '0;
      wy1      <= '0;
      sx0      <= '0;
      sx1      <= '0;
      sy0      <= '0;
      sy1      <= '0;
      color    <= '0;
      scolor   <= '0;
      rem      <= '0;
      idx      <= '0;
      gap      <= 1'b0;
      pt_valid <= 1'b0;
      pt_dc    <= 1'b0;
      pt_data  <= '0;
      abort_q  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      gap <= accept;
      if (wr_winx) begin
        wx0 <= wv[COORD_W-1:0];
        wx1 <= wv[16 +: COORD_W];
      end
      if (wr_winy) begin
        wy0 <= wv[COORD_W-1:0];
        wy1 <= wv[16 +: COORD_W];
      end
      if (wr_ctrl) color <= wv[15:0];
      if (start_ok) begin
        sx0    <= wx0;
        sx1    <= wx1;
        sy0    <= wy0;
        sy1    <= wy1;
        scolor <= wv[15:0];
        rem    <= PIX_W'(npix);
        idx    <= '0;
      end else if (accept && par_st) begin
        idx <= idx + 2'd1;
      end
      if (accept && (state == PIX_LO) && (rem != '0))
        rem <= rem - PIX_W'(1);
      if (wr_data && !busy) begin
        pt_valid <= 1'b1;
        pt_data  <= wv[7:0];
        pt_dc    <= wv[8];
      end else if (accept && !fsm_act) begin
        pt_valid <= 1'b0;
      end
      abort_q <= fsm_act && !leave
              && (abort_q || abort_req);
      // A new event beats the read-clear in the same cycle.
      if (last_px && !abort_now) done <= 1'b1;
      else if (rd_stat)          done <= 1'b0;
      if (start_err || data_err) err <= 1'b1;
      else if (rd_stat)          err <= 1'b0;
    end
  end

  always_comb begin
    bus.read_value_out = '0;
    if (rd) begin
      unique case (1'b1)
        off == 4'h4:
          bus.read_value_out = (32'(wx1) << 16)
                             | 32'(wx0);
        off == 4'h8:
          bus.read_value_out = (32'(wy1) << 16)
                             | 32'(wy0);
        off == 4'hC:
          bus.read_value_out = {color, 13'b0,
                                err, done, busy};
        default: ;
      endcase
    end
  end

  assign bus.ready_out = bus.sel_in;

  logic unused_bits;
  assign unused_bits = ^{bus.address_in, wv};

endmodule

// File: tb/tb_lcd_fill_sequencer.sv
// Self-checking bench for lcd_fill_sequencer with a
// byte-list reference model and random byte_ready.
module tb_lcd_fill_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  lcd_fill_sequencer_if bus ();

  lcd_fill_sequencer #(
    .COORD_W(9),
    .PIX_W(18)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ready_mode = 1;
  int stab_err = 0;
  int thr_err = 0;
  int wr_cnt = 0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  logic prev_v = 1'b0;
  logic prev_acc = 1'b0;
  logic [8:0] prev_b = '0;
  logic mon_acc;
  logic [15:0] m_color = '0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, act, req);
  endtask

  function automatic logic [31:0] st(
    input logic [15:0] c, input bit e,
    input bit d, input bit b);
    return {c, 13'b0, e, d, b};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
      prev_acc = 1'b0;
    end else begin
      mon_acc = bus.byte_valid && bus.byte_ready;
      if (prev_v && !prev_acc &&
          (!bus.byte_valid ||
           {bus.byte_dc, bus.byte_data} != prev_b))
        stab_err++;
      if (mon_acc && prev_acc) thr_err++;
      if (mon_acc)
        got.push_back({bus.byte_dc, bus.byte_data});
      prev_v = bus.byte_valid;
      prev_acc = mon_acc;
      prev_b = {bus.byte_dc, bus.byte_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.byte_ready = 1'b0;
        1: bus.byte_ready = 1'b1;
        default:
          bus.byte_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic bus_wr(input logic [3:0] a,
                        input logic [31:0] d);
    @(posedge clk);
    #1;
    wr_cnt = got.size();
    bus.sel_in = 1'b1;
    bus.read_in = 1'b0;
    bus.write_mask_in = 4'hF;
    bus.address_in = {28'h0, a};
    bus.write_value_in = d;
    @(posedge clk);
    #1;
    bus.sel_in = 1'b0;
    bus.write_mask_in = 4'h0;
  endtask

  task automatic bus_rd(input logic [3:0] a,
                        output logic [31:0] v);
    @(posedge clk);
    #1;
    bus.sel_in = 1'b1;
    bus.read_in = 1'b1;
    bus.address_in = {28'h0, a};
    @(negedge clk);
    v = bus.read_value_out;
    @(posedge clk);
    #1;
    bus.sel_in = 1'b0;
    bus.read_in = 1'b0;
  endtask

  task automatic wait_bytes(input int n,
                            input string tag);
    int k = 0;
    while (got.size() < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (got.size() < n)
      chk({tag, "_timeout"}, got.size(), n);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic push16(input int v);
    exp_q.push_back({1'b1, 8'((v >> 8) & 255)});
    exp_q.push_back({1'b1, 8'(v & 255)});
  endtask

  task automatic build_fill(input int x0, input int x1,
                            input int y0, input int y1,
                            input int c);
    int npx;
    exp_q.delete();
    exp_q.push_back(9'h02A);
    push16(x0);
    push16(x1);
    exp_q.push_back(9'h02B);
    push16(y0);
    push16(y1);
    exp_q.push_back(9'h02C);
    npx = (x1 - x0 + 1) * (y1 - y0 + 1);
    repeat (npx) push16(c);
  endtask

  task automatic start_fill(input int x0, input int x1,
                            input int y0, input int y1,
                            input logic [15:0] c);
    got.delete();
    bus_wr(4'h4, (32'(x1) << 16) | 32'(x0));
    bus_wr(4'h8, (32'(y1) << 16) | 32'(y0));
    bus_wr(4'hC, 32'h0001_0000 | 32'(c));
    m_color = c;
    build_fill(x0, x1, y0, y1, int'(c));
  endtask

  function automatic int prefix_mis();
    int mis = 0;
    for (int i = 0; i < got.size(); i++)
      if (i >= exp_q.size() || got[i] !== exp_q[i])
        mis++;
    return mis;
  endfunction

  task automatic compare_fill(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    chk({tag, "_data"}, prefix_mis(), 0);
  endtask

  logic [8:0] t1 [15] = '{
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
    9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100
  };

  initial begin
    logic [31:0] v;
    int x0, x1, y0, y1;
    logic [15:0] c, c2;
    bus.sel_in = 1'b0;
    bus.read_in = 1'b0;
    bus.write_mask_in = 4'h0;
    bus.address_in = '0;
    bus.write_value_in = '0;
    bus.byte_ready = 1'b1;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.byte_valid), 0);
    chk("rst_data", 32'(bus.byte_data), 0);
    chk("rst_dc", 32'(bus.byte_dc), 0);
    chk("rst_rdata", bus.read_value_out, 0);
    bus_rd(4'hC, v);
    chk("rst_status", v, 0);
    bus_rd(4'h4, v);
    chk("rst_winx", v, 0);

    ready_mode = 1;
    start_fill(0, 1, 0, 0, 16'hF800);
    wait_bytes(15, "t1");
    settle();
    chk("t1_len", got.size(), 15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("t1_b%0d", i),
          (i < got.size()) ? 32'(got[i]) : 32'hDEAD,
          32'(t1[i]));
    bus_rd(4'hC, v);
    chk("t1_status", v, st(16'hF800, 0, 1, 0));
    bus_rd(4'hC, v);
    chk("t1_clr", v, st(16'hF800, 0, 0, 0));
    bus_rd(4'h4, v);
    chk("t1_winx", v, 32'h0001_0000);

    ready_mode = 0;
    @(posedge clk);
    got.delete();
    bus_wr(4'h0, 32'h111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pt_hold",
          {22'b0, bus.byte_valid, bus.byte_dc,
           bus.byte_data}, {22'b0, 2'b11, 8'h11});
    end
    bus_rd(4'hC, v);
    chk("pt_busy", v, st(m_color, 0, 0, 1));
    ready_mode = 1;
    wait_bytes(1, "pt");
    settle();
    chk("pt_len", got.size(), 1);
    chk("pt_byte",
        got.size() > 0 ? 32'(got[0]) : 32'hDEAD,
        32'h111);
    bus_rd(4'hC, v);
    chk("pt_idle", v, st(m_color, 0, 0, 0));

    got.delete();
    bus_wr(4'h4, (32'd3 << 16) | 32'd5);
    bus_wr(4'h8, 32'h0);
    bus_wr(4'hC, 32'h0001_1234);
    m_color = 16'h1234;
    repeat (5) @(negedge clk);
    chk("inv_bytes", got.size(), 0);
    bus_rd(4'hC, v);
    chk("inv_status", v, st(m_color, 1, 0, 0));
    bus_rd(4'hC, v);
    chk("inv_clr", v, st(m_color, 0, 0, 0));

    ready_mode = 2;
    for (int it = 0; it < 6; it++) begin
      x0 = $urandom_range(0, 511);
      x1 = x0 + $urandom_range(0, 3);
      if (x1 > 511) x1 = 511;
      y0 = $urandom_range(0, 511);
      y1 = y0 + $urandom_range(0, 3);
      if (y1 > 511) y1 = 511;
      c = 16'($urandom);
      start_fill(x0, x1, y0, y1, c);
      wait_bytes(exp_q.size(), $sformatf("rnd%0d", it));
      settle();
      compare_fill($sformatf("rnd%0d", it));
      bus_rd(4'hC, v);
      chk($sformatf("rnd%0d_st", it), v,
          st(m_color, 0, 1, 0));
    end

    c2 = 16'($urandom);
    start_fill(0, 9, 0, 9, 16'hF800);
    wait_bytes(60, "big_mid");
    bus_wr(4'h4, 32'($urandom));
    bus_wr(4'hC, 32'h0001_0000 | 32'(c2));
    m_color = c2;
    wait_bytes(211, "big");
    settle();
    chk("big_n", got.size(), 211);
    compare_fill("big");
    bus_rd(4'hC, v);
    chk("big_status", v, st(c2, 1, 1, 0));

    ready_mode = 1;
    start_fill(0, 9, 0, 0, 16'h07E0);
    wait_bytes(17, "abort");
    bus_wr(4'hC, 32'h0002_07E0);
    repeat (6) @(negedge clk);
    chk("abort_extra",
        32'(got.size() - wr_cnt <= 1), 1);
    chk("abort_stop",
        32'(got.size() < exp_q.size()), 1);
    chk("abort_prefix", prefix_mis(), 0);
    bus_rd(4'hC, v);
    chk("abort_status", v, st(m_color, 0, 0, 0));
    got.delete();
    bus_wr(4'h0, 32'h0A5);
    wait_bytes(1, "abort_pt");
    settle();
    chk("abort_pt_len", got.size(), 1);
    chk("abort_pt_byte",
        got.size() > 0 ? 32'(got[0]) : 32'hDEAD,
        32'h0A5);

    ready_mode = 1;
    start_fill(0, 3, 0, 3, 16'hABCD);
    wait_bytes(13, "rst_fill");
    ready_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_pre_valid", 32'(bus.byte_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.byte_valid), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_color = '0;
    ready_mode = 1;
    @(negedge clk);
    bus_rd(4'hC, v);
    chk("rst2_status", v, 0);
    bus_rd(4'h4, v);
    chk("rst2_winx", v, 0);

    chk("stable", stab_err, 0);
    chk("throughput", thr_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
